// File: rtl/mer_meas_ctrl.sv
// MER / symbol-error measurement sequencer for one slicer rail: settle, align to an
// LFSR period boundary, accumulate over N periods, then present frozen results.
module mer_meas_ctrl #(
  parameter int PER_W = 8,
  parameter int SET_W = 4,
  parameter int ESQ_W = 56,
  parameter int CNT_W = 32
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   sym_clk_en,
  input  logic                   cycle,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PER_W-1:0]       num_periods,
  input  logic [SET_W-1:0]       settle_periods,
  input  logic [ESQ_W-1:0]       err_square,
  input  logic                   sym_err,
  output logic                   busy,
  output logic                   done,
  output logic [ESQ_W+PER_W-1:0] esq_sum,
  output logic [CNT_W-1:0]       sym_count,
  output logic [CNT_W-1:0]       sym_err_count,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ARM    = 3'd2,
    S_MEAS   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             st;
  logic [SET_W-1:0]   settle_cnt;
  logic [PER_W-1:0]   per_cnt;
  logic               bnd;

  assign bnd   = cycle & sym_clk_en;
  assign state = st;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      st            <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      esq_sum       <= '0;
      sym_count     <= '0;
      sym_err_count <= '0;
      settle_cnt    <= '0;
      per_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start && !abort) begin
            esq_sum       <= '0;
            sym_count     <= '0;
            sym_err_count <= '0;
            settle_cnt    <= settle_periods;
            per_cnt       <= (num_periods == '0) ? PER_W'(1) : num_periods;
            busy          <= 1'b1;
            st            <= (settle_periods == '0) ? S_ARM : S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end else if (bnd) begin
            settle_cnt <= settle_cnt - SET_W'(1);
            if (settle_cnt == SET_W'(1)) st <= S_ARM;
          end
        end

        // The aligning boundary only marks the start of the window; its data is discarded.
        S_ARM: begin
          if (abort) begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end else if (bnd) begin
            st <= S_MEAS;
          end
        end

        S_MEAS: begin
          if (abort) begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end else begin
            if (sym_clk_en) begin
              if (sym_count != '1) sym_count <= sym_count + CNT_W'(1);
              if (sym_err && (sym_err_count != '1))
                sym_err_count <= sym_err_count + CNT_W'(1);
            end
            if (bnd) begin
              esq_sum <= esq_sum + {{PER_W{1'b0}}, err_square};
              per_cnt <= per_cnt - PER_W'(1);
              if (per_cnt == PER_W'(1)) begin
                st   <= S_DONE;
                done <= 1'b1;
                busy <= 1'b0;
              end
            end
          end
        end

        S_DONE: begin
          st <= S_IDLE;
        end

        default: begin
          st   <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mer_meas_ctrl.sv
// Randomised and directed bench for mer_meas_ctrl, checked every cycle against a
// period-counting reference model plus a few hand-computed literal results.
module tb_mer_meas_ctrl;

  localparam int PER_W = 8;
  localparam int SET_W = 4;
  localparam int ESQ_W = 56;
  localparam int CNT_W = 32;

  logic                   sys_clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   sym_clk_en = 1'b0;
  logic                   cycle = 1'b0;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic [PER_W-1:0]       num_periods = '0;
  logic [SET_W-1:0]       settle_periods = '0;
  logic [ESQ_W-1:0]       err_square = '0;
  logic                   sym_err = 1'b0;
  logic                   busy;
  logic                   done;
  logic [ESQ_W+PER_W-1:0] esq_sum;
  logic [CNT_W-1:0]       sym_count;
  logic [CNT_W-1:0]       sym_err_count;
  logic [2:0]             state;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  mer_meas_ctrl #(.PER_W(PER_W), .SET_W(SET_W), .ESQ_W(ESQ_W), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .reset(reset), .sym_clk_en(sym_clk_en), .cycle(cycle),
    .start(start), .abort(abort), .num_periods(num_periods),
    .settle_periods(settle_periods), .err_square(err_square), .sym_err(sym_err),
    .busy(busy), .done(done), .esq_sum(esq_sum), .sym_count(sym_count),
    .sym_err_count(sym_err_count), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the run is described by how many settle boundaries remain,
  // whether we still wait for the aligning boundary, and how many measured periods remain.
  int          m_settle_left, m_meas_left, m_np;
  bit          m_arm, m_done;
  logic [63:0] m_sum;
  longint      m_cnt, m_errs;

  function automatic int exp_state();
    if (m_done) return 4;
    if (m_meas_left > 0) return 3;
    if (m_arm) return 2;
    if (m_settle_left > 0) return 1;
    return 0;
  endfunction

  always @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      m_settle_left = 0; m_meas_left = 0; m_np = 0; m_arm = 0; m_done = 0;
      m_sum = 0; m_cnt = 0; m_errs = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (exp_state() == 0) begin
      if (start && !abort) begin
        m_sum = 0; m_cnt = 0; m_errs = 0;
        m_np = (num_periods == 0) ? 1 : int'(num_periods);
        if (settle_periods != 0) m_settle_left = int'(settle_periods);
        else m_arm = 1;
      end
    end else if (abort) begin
      m_settle_left = 0; m_arm = 0; m_meas_left = 0;
    end else if (m_settle_left > 0) begin
      if (cycle && sym_clk_en) begin
        m_settle_left--;
        if (m_settle_left == 0) m_arm = 1;
      end
    end else if (m_arm) begin
      if (cycle && sym_clk_en) begin
        m_arm = 0;
        m_meas_left = m_np;
      end
    end else begin
      if (sym_clk_en) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (sym_err && m_errs < 64'hFFFF_FFFF) m_errs++;
        if (cycle) begin
          m_sum = m_sum + 64'(err_square);
          m_meas_left--;
          if (m_meas_left == 0) m_done = 1;
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    check("state", 64'(state), 64'(exp_state()));
    check("busy", 64'(busy), 64'(m_settle_left > 0 || m_arm || m_meas_left > 0));
    check("done", 64'(done), 64'(m_done));
    check("esq_sum", 64'(esq_sum), m_sum);
    check("sym_count", 64'(sym_count), 64'(m_cnt));
    check("sym_err_count", 64'(sym_err_count), 64'(m_errs));
    if (done) done_seen++;
  end

  task automatic clk1();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic tick(input bit c, input bit e, input logic [ESQ_W-1:0] v);
    sym_clk_en = 1'b1; cycle = c; sym_err = e; err_square = v;
    clk1();
    sym_clk_en = 1'b0; cycle = 1'b0; sym_err = 1'b0;
    clk1();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    clk1();
    start = 1'b0;
  endtask

  int d0;

  initial begin
    // Reset state
    clk1(); clk1();
    check("rst_state", 64'(state), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_sum", 64'(esq_sum), 0);
    reset = 1'b1;
    clk1();

    // Test 1 (with unqualified cycle during SETTLE)
    num_periods = 2; settle_periods = 1; d0 = done_seen;
    pulse_start();
    check("t1_settle", 64'(state), 1);
    num_periods = 9; settle_periods = 3;
    cycle = 1'b1;
    repeat (3) clk1();
    cycle = 1'b0;
    check("t6_still_settle", 64'(state), 1);
    for (int s = 0; s < 32; s++) begin
      logic [ESQ_W-1:0] v;
      bit e;
      v = (s == 23) ? ESQ_W'(100) : (s == 31) ? ESQ_W'(300) : ESQ_W'(999);
      e = (s == 3 || s == 12 || s == 18 || s == 20 || s == 25);
      tick(s % 8 == 7, e, v);
    end
    check("t1_sum", 64'(esq_sum), 400);
    check("t1_cnt", 64'(sym_count), 16);
    check("t1_errs", 64'(sym_err_count), 3);
    check("t1_done_pulses", 64'(done_seen - d0), 1);
    check("t1_busy", 64'(busy), 0);

    // Test 2: num_periods=0, no settle
    num_periods = 0; settle_periods = 0; d0 = done_seen;
    pulse_start();
    check("t2_arm", 64'(state), 2);
    tick(1, 0, ESQ_W'(56'h555));
    tick(1, 0, ESQ_W'(56'h00_0000_0000_0ABC));
    check("t2_sum", 64'(esq_sum), 64'hABC);
    check("t2_cnt", 64'(sym_count), 1);
    check("t2_done_pulses", 64'(done_seen - d0), 1);

    // Test 3: start re-pulsed and num_periods changed mid-run
    num_periods = 2; settle_periods = 0; d0 = done_seen;
    pulse_start();
    tick(1, 0, ESQ_W'(7));
    start = 1'b1; num_periods = 5;
    tick(0, 1, ESQ_W'(0));
    tick(1, 0, ESQ_W'(50));
    tick(0, 0, ESQ_W'(0));
    tick(1, 1, ESQ_W'(60));
    start = 1'b0;
    check("t3_sum", 64'(esq_sum), 110);
    check("t3_cnt", 64'(sym_count), 4);
    check("t3_errs", 64'(sym_err_count), 2);
    check("t3_done_pulses", 64'(done_seen - d0), 1);
    clk1();
    check("t3_idle", 64'(state), 0);

    // Test 4: abort together with a MEAS boundary
    num_periods = 3; d0 = done_seen;
    pulse_start();
    tick(1, 0, ESQ_W'(1));
    tick(1, 0, ESQ_W'(10));
    sym_clk_en = 1'b1; cycle = 1'b1; sym_err = 1'b1; err_square = ESQ_W'(20); abort = 1'b1;
    clk1();
    abort = 1'b0; sym_clk_en = 1'b0; cycle = 1'b0; sym_err = 1'b0;
    check("t4_state", 64'(state), 0);
    check("t4_sum", 64'(esq_sum), 10);
    check("t4_cnt", 64'(sym_count), 1);
    tick(1, 0, ESQ_W'(5));
    tick(1, 0, ESQ_W'(5));
    check("t4_no_done", 64'(done_seen - d0), 0);
    check("t4_sum_hold", 64'(esq_sum), 10);

    // Test 5: asynchronous reset mid-MEAS
    num_periods = 100;
    pulse_start();
    tick(1, 0, ESQ_W'(3));
    for (int i = 0; i < 37; i++) tick(0, 1, ESQ_W'(0));
    check("t5_cnt37", 64'(sym_count), 37);
    reset = 1'b0;
    #1;
    check("t5_async_state", 64'(state), 0);
    check("t5_async_cnt", 64'(sym_count), 0);
    check("t5_async_errs", 64'(sym_err_count), 0);
    check("t5_async_busy", 64'(busy), 0);
    clk1();
    reset = 1'b1;
    num_periods = 1; d0 = done_seen;
    pulse_start();
    tick(1, 0, ESQ_W'(9));
    tick(1, 1, ESQ_W'(77));
    check("t5_rerun_sum", 64'(esq_sum), 77);
    check("t5_rerun_done", 64'(done_seen - d0), 1);

    // Randomised phase
    for (int i = 0; i < 4000; i++) begin
      sym_clk_en = ($urandom_range(0, 2) == 0);
      cycle = ($urandom_range(0, 3) == 0);
      sym_err = $urandom_range(0, 1) == 1;
      err_square = {24'($urandom), 32'($urandom)};
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 149) == 0);
      num_periods = PER_W'($urandom_range(0, 3));
      settle_periods = SET_W'($urandom_range(0, 2));
      clk1();
    end
    start = 1'b0; abort = 1'b0; sym_clk_en = 1'b0; cycle = 1'b0;
    clk1(); clk1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mer_meas_ctrl.md
Name: mer_meas_ctrl

Overview:
Sequences one MER/symbol-error measurement run on the I or Q slicer datapath.
- On `start`, flushes the pipeline for a programmable number of LFSR periods, then aligns to a period boundary.
- Over N LFSR periods it sums the per-period squared-error average and counts symbols and symbol errors.
- It then presents frozen results with a one-cycle `done` strobe.
- Sits between the ISSP/KEY control and the avg_err_squared_55 / symbol-compare logic; one instance per rail.

Parameters:
- PER_W, 8, width of `num_periods` and of the internal period counter.
- SET_W, 4, width of `settle_periods` and of the internal settle counter.
- ESQ_W, 56, width of the `err_square` input.
- CNT_W, 32, width of the symbol and symbol-error counters.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sym_clk_en  in  1  symbol-rate enable, one sys_clk wide.
- cycle  in  1  LFSR period marker from LFSR_22.
- start  in  1  level/pulse request to begin a run.
- abort  in  1  cancel the current run.
- num_periods  in  PER_W  number of measured periods; 0 is treated as 1.
- settle_periods  in  SET_W  number of flush periods before arming; 0 means no settle.
- err_square  in  ESQ_W  per-period mean-square error; valid on a boundary.
- sym_err  in  1  registered symbol-error flag from the compare stage.
- busy  out  1  high in SETTLE, ARM and MEAS.
- done  out  1  one-cycle strobe on run completion.
- esq_sum  out  ESQ_W+PER_W  sum of err_square over the measured periods.
- sym_count  out  CNT_W  symbols counted in MEAS.
- sym_err_count  out  CNT_W  symbol errors counted in MEAS.
- state  out  3  encoded state: IDLE=0, SETTLE=1, ARM=2, MEAS=3, DONE=4.

Behaviour:
- Boundary definition: bnd = cycle & sym_clk_en.
- Reset (asynchronous, reset=0):
  - state=IDLE; busy=0, done=0.
  - esq_sum, sym_count, sym_err_count = 0.
  - Internal counters = 0.
- Number of periods: Np = (num_periods==0) ? 1 : num_periods.
- Configuration capture: `num_periods` and `settle_periods` are captured on the start-accept edge. Later changes do not affect the run in progress.
- IDLE:
  - start=1 and abort=0 → next state SETTLE, or ARM if settle_periods==0.
  - On that edge: clear the three result registers and load the settle and period counters.
  - busy rises on the same edge.
- SETTLE:
  - Each bnd decrements the settle counter.
  - The bnd that takes it to 0 moves the FSM to ARM.
  - Nothing is accumulated.
- ARM: the first bnd moves the FSM to MEAS. That boundary's err_square and sym_err are not used.
- MEAS, on each sym_clk_en:
  - sym_count += 1.
  - sym_err_count += sym_err.
  - Both counters saturate at all-ones.
- MEAS, on each bnd:
  - esq_sum += zero-extended err_square.
  - The period counter decrements.
  - The bnd that brings it to 0 is included in all sums, then the FSM moves to DONE.
  - Sums over exactly Np periods never overflow.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Next state IDLE.
  - Results hold until the next accepted start.
- Latency: done rises one sys_clk after the final bnd edge.
- start while busy or in DONE: ignored; not queued.
- abort in SETTLE/ARM/MEAS:
  - Next state IDLE; busy drops; no done.
  - Results freeze at their partial values.
  - abort has priority over bnd and start in the same cycle.
- abort in IDLE or DONE: no effect.
- cycle without sym_clk_en: ignored.
- Reset asserted mid-run: immediate return to IDLE with all outputs cleared.
- All outputs are registered.

Test Plan:
1. Reset, num_periods=2, settle_periods=1, start pulse, bnd every 8 sym_clk_en, err_square=100 then 300, sym_err high on 3 symbols in the window → one SETTLE bnd, one ARM bnd, then DONE; esq_sum=400, sym_count=16, sym_err_count=3, done=1 for 1 cycle exactly 1 clock after the 3rd post-start bnd... more precisely after the final (4th) bnd, busy low afterwards.
2. num_periods=0, settle_periods=0, err_square=0x00_0000_0000_0ABC → ARM directly after start; single measured period; esq_sum=0xABC; done after 2 bnds.
3. start re-pulsed during MEAS, and num_periods changed from 2 to 5 mid-run → ignored; run ends after 2 periods with unchanged results.
4. abort asserted together with a MEAS bnd → state=0 next clock; that bnd not accumulated; done never asserts; results hold partial values.
5. reset driven low mid-MEAS with sym_count=37 → asynchronous clear; all outputs 0 before the next edge; start after release runs normally.
6. cycle asserted with sym_clk_en=0 during SETTLE → no decrement; state stays SETTLE until a qualified bnd.
